// File: rtl/uart_rx_oversampler.sv
// 16x-oversampling 8N1 UART receive front-end with 2-of-3 majority sampling,
// false-start rejection, framing-error and line-break detection.
module uart_rx_oversampler #(
   parameter int CLK_FREQ   = 10000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_break,
   output logic       o_busy
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int H   = OVERSAMPLE / 2;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(OVERSAMPLE);

   localparam logic [PW-1:0] PS_LAST   = PW'(DIV - 1);
   localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SC_VOTE0  = SW'(H - 1);
   localparam logic [SW-1:0] SC_VOTE1  = SW'(H);
   localparam logic [SW-1:0] SC_DECIDE = SW'(H + 1);

   generate
      if (DIV < 2) begin : g_badDiv
         $error("uart_rx_oversampler: clock too slow for BAUD*OVERSAMPLE (DIV < 2)");
      end
      if (OVERSAMPLE < 8) begin : g_badOversample
         $error("uart_rx_oversampler: OVERSAMPLE must be at least 8");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t        r_state;
   state_t        w_nextState;

   logic          r_rxMeta;
   logic          r_rxSync;
   logic [PW-1:0] r_prescale;
   logic [SW-1:0] r_sampleCnt;
   logic [2:0]    r_bitIdx;
   logic          r_vote0;
   logic          r_vote1;
   logic [7:0]    r_shiftReg;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_frameErr;
   logic          r_break;

   logic          w_counting;
   logic          w_tick;
   logic          w_wrap;
   logic          w_decide;
   logic          w_bit;
   logic          w_startFrame;
   logic          w_shiftEn;
   logic          w_validNext;
   logic          w_frameErrNext;
   logic          w_breakNext;

   // Prescaler and sample counter only run while a frame is being received
   assign w_counting = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
   assign w_tick     = w_counting && (r_prescale == PS_LAST);
   assign w_wrap     = w_tick && (r_sampleCnt == SC_LAST);
   assign w_decide   = w_tick && (r_sampleCnt == SC_DECIDE);

   // The third vote is the live synchronised sample at the decision tick
   assign w_bit = (r_vote0 & r_vote1) | (r_vote0 & r_rxSync) | (r_vote1 & r_rxSync);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_startFrame   = 1'b0;
      w_shiftEn      = 1'b0;
      w_validNext    = 1'b0;
      w_frameErrNext = 1'b0;
      w_breakNext    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rxSync) begin
               w_nextState  = S_START;
               w_startFrame = 1'b1;
            end
         end
         S_START: begin
            if (w_decide && w_bit) begin
               w_nextState = S_IDLE;
            end else if (w_wrap) begin
               w_nextState = S_DATA;
            end
         end
         S_DATA: begin
            w_shiftEn = w_decide;
            if (w_wrap && (r_bitIdx == 3'd7)) begin
               w_nextState = S_STOP;
            end
         end
         S_STOP: begin
            // Leave at the stop-bit decision so a following start bit is not missed
            if (w_decide) begin
               if (w_bit) begin
                  w_validNext = 1'b1;
                  w_nextState = S_IDLE;
               end else if (r_shiftReg != 8'h00) begin
                  w_frameErrNext = 1'b1;
                  w_nextState    = S_WAIT_IDLE;
               end else begin
                  w_breakNext = 1'b1;
                  w_nextState = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (r_rxSync) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Synchroniser, bit timing, vote capture, shift register and output strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rxMeta    <= 1'b1;
         r_rxSync    <= 1'b1;
         r_prescale  <= '0;
         r_sampleCnt <= '0;
         r_bitIdx    <= 3'd0;
         r_vote0     <= 1'b1;
         r_vote1     <= 1'b1;
         r_shiftReg  <= 8'h00;
         r_data      <= 8'h00;
         r_valid     <= 1'b0;
         r_frameErr  <= 1'b0;
         r_break     <= 1'b0;
      end else begin
         r_rxMeta <= i_rx;
         r_rxSync <= r_rxMeta;

         if (w_startFrame) begin
            r_prescale  <= '0;
            r_sampleCnt <= '0;
            r_bitIdx    <= 3'd0;
         end else if (w_counting) begin
            r_prescale <= w_tick ? '0 : r_prescale + PW'(1);
            if (w_tick) begin
               r_sampleCnt <= (r_sampleCnt == SC_LAST) ? '0 : r_sampleCnt + SW'(1);
               if (r_sampleCnt == SC_VOTE0) begin
                  r_vote0 <= r_rxSync;
               end
               if (r_sampleCnt == SC_VOTE1) begin
                  r_vote1 <= r_rxSync;
               end
               if (w_wrap && (r_state == S_DATA)) begin
                  r_bitIdx <= r_bitIdx + 3'd1;
               end
            end
         end

         if (w_shiftEn) begin
            r_shiftReg <= {w_bit, r_shiftReg[7:1]};
         end

         r_valid    <= w_validNext;
         r_frameErr <= w_frameErrNext;
         r_break    <= w_breakNext;
         if (w_validNext) begin
            r_data <= r_shiftReg;
         end
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frameErr;
   assign o_break     = r_break;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: good frames, false start, framing error,
// break, back-to-back frames with baud skew, sampling spikes and mid-frame reset.
module tb_uart_rx_oversampler;

   localparam int BIT_CLK = 160;

   logic       clk;
   logic       rst_n;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_break;
   logic       o_busy;

   int         errCount   = 0;
   int         checkCount = 0;
   int         nValid     = 0;
   int         nFrame     = 0;
   int         nBreak     = 0;
   int         nMulti     = 0;
   logic [7:0] lastData   = 8'h00;
   logic [7:0] dataQ[$];

   uart_rx_oversampler #(
      .CLK_FREQ  (1600000),
      .BAUD      (10000),
      .OVERSAMPLE(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rx       (i_rx),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_frame_err(o_frame_err),
      .o_break    (o_break),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled on the falling edge away from the active edge
   always @(negedge clk) begin
      if (o_valid) begin
         nValid++;
         lastData = o_data;
         dataQ.push_back(o_data);
      end
      if (o_frame_err) nFrame++;
      if (o_break) nBreak++;
      if ((int'(o_valid) + int'(o_frame_err) + int'(o_break)) > 1) nMulti++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Sends one 8N1 frame; spikeAt >= 0 inverts each data bit for one clock at that offset
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int bitClk, input int spikeAt);
      i_rx = 1'b0;
      repeat (bitClk) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_rx = data[i];
         if (spikeAt >= 0) begin
            repeat (spikeAt) @(negedge clk);
            i_rx = ~data[i];
            @(negedge clk);
            i_rx = data[i];
            repeat (bitClk - spikeAt - 1) @(negedge clk);
         end else begin
            repeat (bitClk) @(negedge clk);
         end
      end
      i_rx = stopBit;
      repeat (bitClk) @(negedge clk);
   endtask

   initial begin
      int bauds[3];
      int base;
      bauds = '{160, 155, 165};
      rst_n = 1'b0;
      i_rx  = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("rst_valid", 32'(o_valid), 32'd0);
      checkOutput("rst_ferr", 32'(o_frame_err), 32'd0);
      checkOutput("rst_break", 32'(o_break), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_data", 32'(o_data), 32'h00);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] test 1: single byte 0x61");
      applyStimulus(8'h61, 1'b1, BIT_CLK, -1);
      repeat (BIT_CLK) @(negedge clk);
      checkOutput("t1_nvalid", 32'(nValid), 32'd1);
      checkOutput("t1_data", 32'(lastData), 32'h61);
      checkOutput("t1_nferr", 32'(nFrame), 32'd0);
      checkOutput("t1_nbreak", 32'(nBreak), 32'd0);
      checkOutput("t1_busy", 32'(o_busy), 32'd0);

      $display("[TB] test 2: 40-clock low glitch");
      i_rx = 1'b0;
      repeat (40) @(negedge clk);
      i_rx = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("t2_busy_start", 32'(o_busy), 32'd1);
      repeat (200) @(negedge clk);
      checkOutput("t2_busy_end", 32'(o_busy), 32'd0);
      checkOutput("t2_nvalid", 32'(nValid), 32'd1);
      checkOutput("t2_nferr", 32'(nFrame), 32'd0);
      checkOutput("t2_nbreak", 32'(nBreak), 32'd0);

      $display("[TB] test 3: framing error on 0x55");
      applyStimulus(8'h55, 1'b0, BIT_CLK, -1);
      repeat (2 * BIT_CLK) @(negedge clk);
      checkOutput("t3_busy_low", 32'(o_busy), 32'd1);
      checkOutput("t3_nferr", 32'(nFrame), 32'd1);
      i_rx = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("t3_busy_end", 32'(o_busy), 32'd0);
      checkOutput("t3_nvalid", 32'(nValid), 32'd1);
      checkOutput("t3_nbreak", 32'(nBreak), 32'd0);

      $display("[TB] test 4: 20-bit break");
      i_rx = 1'b0;
      repeat (15 * BIT_CLK) @(negedge clk);
      checkOutput("t4_busy_mid", 32'(o_busy), 32'd1);
      checkOutput("t4_nbreak_mid", 32'(nBreak), 32'd1);
      repeat (5 * BIT_CLK) @(negedge clk);
      i_rx = 1'b1;
      @(negedge clk);
      checkOutput("t4_busy_sync", 32'(o_busy), 32'd1);
      repeat (20) @(negedge clk);
      checkOutput("t4_busy_end", 32'(o_busy), 32'd0);
      checkOutput("t4_nbreak_end", 32'(nBreak), 32'd1);
      checkOutput("t4_nferr", 32'(nFrame), 32'd1);

      $display("[TB] test 5: back-to-back 'h','i' at nominal and +/-3%% baud");
      for (int k = 0; k < 3; k++) begin
         dataQ.delete();
         base = nValid;
         applyStimulus(8'h68, 1'b1, bauds[k], -1);
         applyStimulus(8'h69, 1'b1, bauds[k], -1);
         repeat (200) @(negedge clk);
         checkOutput($sformatf("t5_count_%0d", bauds[k]), 32'(nValid - base), 32'd2);
         checkOutput($sformatf("t5_d0_%0d", bauds[k]),
                     (dataQ.size() > 0) ? 32'(dataQ[0]) : 32'hFFFF_FFFF, 32'h68);
         checkOutput($sformatf("t5_d1_%0d", bauds[k]),
                     (dataQ.size() > 1) ? 32'(dataQ[1]) : 32'hFFFF_FFFF, 32'h69);
      end

      $display("[TB] test 6: spikes in 0xA5, then reset mid-frame, then 0x3C");
      base = nValid;
      applyStimulus(8'hA5, 1'b1, BIT_CLK, 88);
      repeat (100) @(negedge clk);
      checkOutput("t6_spike_count", 32'(nValid - base), 32'd1);
      checkOutput("t6_spike_data", 32'(lastData), 32'hA5);

      base = nValid;
      i_rx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         i_rx = (8'h12 >> i) & 8'h01;
         repeat (BIT_CLK) @(negedge clk);
      end
      i_rx = 1'b1;
      repeat (80) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("t6_rst_busy", 32'(o_busy), 32'd0);
      checkOutput("t6_rst_data", 32'(o_data), 32'h00);
      checkOutput("t6_rst_valid", 32'(o_valid), 32'd0);
      repeat (300) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput("t6_rst_nostrobe", 32'(nValid - base), 32'd0);
      checkOutput("t6_rst_busy_after", 32'(o_busy), 32'd0);
      applyStimulus(8'h3C, 1'b1, BIT_CLK, -1);
      repeat (100) @(negedge clk);
      checkOutput("t6_clean_count", 32'(nValid - base), 32'd1);
      checkOutput("t6_clean_data", 32'(lastData), 32'h3C);

      checkOutput("final_nferr", 32'(nFrame), 32'd1);
      checkOutput("final_nbreak", 32'(nBreak), 32'd1);
      checkOutput("final_exclusive", 32'(nMulti), 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
